// File: rtl/clkgen_pkg.sv
// Shared types and sizing helpers for the multi-channel clock divider.
package clkgen_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_LOCKED,
        ST_UPDATE
    } ctrl_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold the value v, never narrower than one bit.
    function automatic int val_w(input int v);
        return (v > 1) ? $clog2(v + 1) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, shadow/active ratio and phase, registered outputs.
module clkdiv_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_phase,
    output logic             outclk,
    output logic             outstb,
    output logic             pending
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_phase_q, sh_phase_d;
    logic             pend_q, pend_d;
    logic             outclk_q, outclk_d;
    logic             outstb_q, outstb_d;

    logic             wrap;
    logic [CNT_W:0]   half;
    logic             eff_pend;
    logic [CNT_W-1:0] eff_div, eff_phase;

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        wrap      = (cnt_q == div_q - ONE);
        half      = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;
        // A write landing on the wrap or sync cycle is committed right away.
        eff_pend  = pend_q | wr;
        eff_div   = wr ? wr_div : sh_div_q;
        eff_phase = wr ? wr_phase : sh_phase_q;

        cnt_d      = cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        sh_div_d   = eff_div;
        sh_phase_d = eff_phase;
        pend_d     = eff_pend;
        outclk_d   = run & ({1'b0, cnt_q} < half);
        outstb_d   = run & wrap;

        if (run) begin
            if (sync || wrap) begin
                if (eff_pend) begin
                    div_d   = eff_div;
                    phase_d = eff_phase;
                    cnt_d   = eff_phase;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = sync ? phase_q : '0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // NOTE: shadow registers are reset too, so a pending write never survives reset.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DIV_DEFAULT);
            phase_q    <= '0;
            sh_div_q   <= '0;
            sh_phase_q <= '0;
            pend_q     <= 1'b0;
            outclk_q   <= 1'b0;
            outstb_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            sh_div_q   <= sh_div_d;
            sh_phase_q <= sh_phase_d;
            pend_q     <= pend_d;
            outclk_q   <= outclk_d;
            outstb_q   <= outstb_d;
        end
    end

    assign outclk  = outclk_q;
    assign outstb  = outstb_q;
    assign pending = pend_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel clock divider: config decode, sync fan-out and lock controller.
module multi_clk_div
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                     refclk,
    input  logic                     rst_n,
    input  logic                     cfg_wr,
    input  logic [idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]         cfg_div,
    input  logic [CNT_W-1:0]         cfg_phase,
    input  logic                     sync_req,
    output logic [NUM_CH-1:0]        outclk,
    output logic [NUM_CH-1:0]        outstb,
    output logic                     locked,
    output logic                     cfg_err
);

    localparam int               SET_W    = val_w(LOCK_CYCLES);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    ctrl_state_e       state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              run_q;
    logic              locked_q, locked_d;
    logic              cfg_err_q, cfg_err_d;
    logic              accept;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] ch_pending;

    always_comb begin
        accept = cfg_wr && (cfg_div != '0) && (cfg_phase < cfg_div)
                 && (32'(cfg_ch) < 32'(NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = accept && (32'(cfg_ch) == 32'(i));
        end
        cfg_err_d = cfg_wr & ~accept;

        state_d  = state_q;
        settle_d = settle_q;
        // A sync commits every shadow, so it always restarts the settle count.
        case (state_q)
            ST_SETTLE: begin
                if (sync_req) begin
                    settle_d = '0;
                end else if (accept) begin
                    state_d = ST_UPDATE;
                end else if (run_q) begin
                    if (settle_q == SET_LAST) state_d = ST_LOCKED;
                    else                      settle_d = settle_q + SET_W'(1);
                end
            end
            ST_LOCKED: begin
                if (sync_req)    state_d = ST_SETTLE;
                else if (accept) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (sync_req || (!accept && (ch_pending == '0))) state_d = ST_SETTLE;
            end
            default: state_d = ST_SETTLE;
        endcase
        if (state_d != ST_SETTLE) settle_d = '0;

        locked_d = (state_d == ST_LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SETTLE;
            settle_q  <= '0;
            run_q     <= 1'b0;
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            run_q     <= 1'b1;
            locked_q  <= locked_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .run      (run_q),
            .sync     (sync_req),
            .wr       (ch_wr[g]),
            .wr_div   (cfg_div),
            .wr_phase (cfg_phase),
            .outclk   (outclk[g]),
            .outstb   (outstb[g]),
            .pending  (ch_pending[g])
        );
    end

    assign locked  = locked_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div: directed scenarios plus randomized traffic vs a cycle model.
module tb_multi_clk_div;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int DIV_DEFAULT = 2;
    localparam int LOCK_CYCLES = 16;

    logic              refclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              sync_req = 1'b0;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outstb;
    logic              locked;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    multi_clk_div #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .sync_req  (sync_req),
        .outclk    (outclk),
        .outstb    (outstb),
        .locked    (locked),
        .cfg_err   (cfg_err)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Behavioural model: per-channel position in the period plus active and pending settings.
    int m_cnt   [NUM_CH];
    int m_div   [NUM_CH];
    int m_phase [NUM_CH];
    int m_sdiv  [NUM_CH];
    int m_sph   [NUM_CH];
    bit m_pend  [NUM_CH];
    bit m_run;
    logic [NUM_CH-1:0] e_clk;
    logic [NUM_CH-1:0] e_stb;
    logic              e_err;

    task automatic model_reset;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_div[i] = DIV_DEFAULT; m_phase[i] = 0;
            m_sdiv[i] = 0; m_sph[i] = 0; m_pend[i] = 0;
        end
        m_run = 0; e_clk = '0; e_stb = '0; e_err = 0;
    endtask

    task automatic model_step(input bit wr, input int ch, input int dv, input int ph, input bit sy);
        bit acc;
        acc = wr && (dv != 0) && (ph < dv) && (ch < NUM_CH);
        e_err = wr && !acc;
        for (int i = 0; i < NUM_CH; i++) begin
            e_clk[i] = m_run && (m_cnt[i] < (m_div[i] + 1) / 2);
            e_stb[i] = m_run && (m_cnt[i] == m_div[i] - 1);
            if (acc && ch == i) begin
                m_sdiv[i] = dv; m_sph[i] = ph; m_pend[i] = 1;
            end
            if (m_run) begin
                if (sy || m_cnt[i] == m_div[i] - 1) begin
                    if (m_pend[i]) begin
                        m_div[i] = m_sdiv[i]; m_phase[i] = m_sph[i]; m_pend[i] = 0;
                        m_cnt[i] = m_phase[i];
                    end else begin
                        m_cnt[i] = sy ? m_phase[i] : 0;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_run = 1;
    endtask

    // One refclk cycle: drive inputs, advance the model at the edge, compare just after it.
    task automatic tick(input bit wr, input int ch, input int dv, input int ph, input bit sy);
        cfg_wr = wr; cfg_ch = ch[1:0]; cfg_div = dv[15:0]; cfg_phase = ph[15:0]; sync_req = sy;
        @(posedge refclk);
        model_step(wr, ch, dv, ph, sy);
        #1;
        cfg_wr = 1'b0; sync_req = 1'b0;
        checks++;
        if (outclk !== e_clk) begin
            errors++;
            $display("FAIL outclk @%0t: got %b expected %b", $time, outclk, e_clk);
        end
        checks++;
        if (outstb !== e_stb) begin
            errors++;
            $display("FAIL outstb @%0t: got %b expected %b", $time, outstb, e_stb);
        end
        checks++;
        if (cfg_err !== e_err) begin
            errors++;
            $display("FAIL cfg_err @%0t: got %b expected %b", $time, cfg_err, e_err);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        checks++;
        if ({outclk, outstb, locked, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero", {outclk, outstb, locked, cfg_err});
        end
        @(negedge refclk);
        rst_n = 1'b1;
        n = 0;
        while (locked !== 1'b1 && n < 100) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != LOCK_CYCLES + 1) begin
            errors++;
            $display("FAIL lock_after_reset: locked rose after %0d cycles, expected %0d", n, LOCK_CYCLES + 1);
        end
        idle(4);
    endtask

    task automatic test_write_div5;
        int n, highs, stbs;
        tick(1, 1, 5, 0, 0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL locked_drop_on_write: got %b expected 0", locked);
        end
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n <= LOCK_CYCLES || n >= 200) begin
            errors++;
            $display("FAIL relock_after_write: relocked after %0d cycles, expected between %0d and 199",
                     n, LOCK_CYCLES + 1);
        end
        highs = 0; stbs = 0;
        for (int k = 0; k < 10; k++) begin
            tick(0, 0, 0, 0, 0);
            highs += int'(outclk[1]);
            stbs  += int'(outstb[1]);
        end
        checks++;
        if (highs != 6 || stbs != 2) begin
            errors++;
            $display("FAIL div5_shape: %0d high and %0d strobes in 10 cycles, expected 6 and 2", highs, stbs);
        end
    endtask

    task automatic test_reject;
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL reject_precondition: locked=%b expected 1", locked);
        end
        tick(1, 0, 0, 0, 0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL reject_div0_locked: got %b expected 1", locked);
        end
        idle(3);
        tick(1, 0, 4, 4, 0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL reject_phase_locked: got %b expected 1", locked);
        end
        idle(3);
    endtask

    task automatic test_phase_sync;
        int t0, t2;
        tick(1, 0, 4, 0, 0);
        tick(1, 2, 4, 2, 0);
        idle(2);
        tick(0, 0, 0, 0, 1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL locked_drop_on_sync: got %b expected 0", locked);
        end
        t0 = -1; t2 = -1;
        for (int k = 1; k <= 8; k++) begin
            tick(0, 0, 0, 0, 0);
            if (outstb[0] === 1'b1 && t0 < 0) t0 = k;
            if (outstb[2] === 1'b1 && t2 < 0) t2 = k;
        end
        checks++;
        if (t0 < 0 || t2 < 0 || ((t2 - t0 + 8) % 4) != 2) begin
            errors++;
            $display("FAIL phase_offset: ch0 strobe at %0d ch2 strobe at %0d, expected 2-cycle offset", t0, t2);
        end
        idle(LOCK_CYCLES + 4);
    endtask

    task automatic test_div1;
        int held;
        tick(1, 3, 1, 0, 0);
        idle(6);
        held = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0, 0, 0);
            if (outclk[3] === 1'b1 && outstb[3] === 1'b1) held++;
        end
        checks++;
        if (held != 5) begin
            errors++;
            $display("FAIL div1_held_high: high in %0d of 5 cycles, expected 5", held);
        end
    endtask

    task automatic test_reset_in_update;
        int n, highs, stbs;
        n = 0;
        while (m_cnt[1] != 0 && n < 10) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        tick(1, 1, 7, 3, 0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL update_entered: locked=%b expected 0", locked);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({outclk, outstb, locked, cfg_err} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b expected all zero", {outclk, outstb, locked, cfg_err});
        end
        @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        idle(12);
        highs = 0; stbs = 0;
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 0, 0, 0);
            highs += int'(outclk[1]);
            stbs  += int'(outstb[1]);
        end
        checks++;
        if (highs != 4 || stbs != 4) begin
            errors++;
            $display("FAIL default_restored: %0d high and %0d strobes in 8 cycles, expected 4 and 4", highs, stbs);
        end
    endtask

    task automatic test_random;
        int r, ch, dv, ph;
        bit wr, sy;
        for (int k = 0; k < 1500; k++) begin
            r  = int'($urandom_range(0, 99));
            wr = (r < 8);
            sy = (r >= 6 && r < 10);
            ch = int'($urandom_range(0, NUM_CH - 1));
            dv = int'($urandom_range(0, 9));
            ph = int'($urandom_range(0, 9));
            tick(wr, ch, dv, ph, sy);
        end
    endtask

    initial begin
        test_reset();
        test_write_div5();
        test_reject();
        test_phase_sync();
        test_div1();
        test_reset_in_update();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
